alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared, multi-cycle ALU
// One operation in flight; operands are registered to the ALU, result captured after SETTLE_CYCLES.
module alu_arbiter #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_data1,
  input  logic [7:0] req0_data2,
  input  logic [2:0] req0_select,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_data1,
  input  logic [7:0] req1_data2,
  input  logic [2:0] req1_select,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_result,
  output logic       rsp_zero,
  output logic [7:0] alu_data1,
  output logic [7:0] alu_data2,
  output logic [2:0] alu_select,
  input  logic [7:0] alu_result,
  input  logic       alu_zero
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] count;
  logic       last_grant;
  logic       winner;
  logic       accept;
  logic       capture;
  logic       consume;
  logic [7:0] win_data1;
  logic [7:0] win_data2;
  logic [2:0] win_select;

  // Under contention the requester that did not win last time gets the grant.
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) begin
      winner = ~last_grant;
    end else if (req1_valid) begin
      winner = 1'b1;
    end
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!reset && state == IDLE) begin
      req0_ready = req0_valid && !winner;
      req1_ready = req1_valid && winner;
    end
  end

  always_comb begin
    win_data1  = winner ? req1_data1  : req0_data1;
    win_data2  = winner ? req1_data2  : req0_data2;
    win_select = winner ? req1_select : req0_select;
  end

  assign accept  = req0_ready || req1_ready;
  assign capture = (state == SETTLE) && (count == 4'd1);
  assign consume = (state == RESP) && rsp_valid && rsp_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)  state_nxt = SETTLE;
      SETTLE:  if (capture) state_nxt = RESP;
      RESP:    if (consume) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath registers; ALU operands only move on an accept edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= 4'd0;
      last_grant <= 1'b1;
      alu_data1  <= 8'd0;
      alu_data2  <= 8'd0;
      alu_select <= 3'd0;
      rsp_id     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= 8'd0;
      rsp_zero   <= 1'b0;
    end else begin
      if (accept) begin
        alu_data1  <= win_data1;
        alu_data2  <= win_data2;
        alu_select <= win_select;
        rsp_id     <= winner;
        last_grant <= winner;
        count      <= SETTLE_INIT;
      end else if (state == SETTLE) begin
        count <= count - 4'd1;
      end
      if (capture) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
        rsp_valid  <= 1'b1;
      end else if (consume) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - bench for alu_arbiter, two instances (SETTLE_CYCLES 1 and 3)
// A transaction-level model predicts grants, response timing and contents each cycle.
module tb_alu_arbiter;

  localparam int S0 = 1;
  localparam int S1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [2];
  logic       r0v [2];
  logic       r0r [2];
  logic [7:0] r0a [2];
  logic [7:0] r0b [2];
  logic [2:0] r0s [2];
  logic       r1v [2];
  logic       r1r [2];
  logic [7:0] r1a [2];
  logic [7:0] r1b [2];
  logic [2:0] r1s [2];
  logic       rspv [2];
  logic       rspr [2];
  logic       rid [2];
  logic [7:0] rres [2];
  logic       rz [2];
  logic [7:0] ad1 [2];
  logic [7:0] ad2 [2];
  logic [2:0] asel [2];
  logic [7:0] ares [2];
  logic       azr [2];

  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    case (s)
      3'b000:  return a - b;
      3'b001:  return a + b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a;
      default: return 8'h00;
    endcase
  endfunction

  assign ares[0] = alu_fn(ad1[0], ad2[0], asel[0]);
  assign ares[1] = alu_fn(ad1[1], ad2[1], asel[1]);
  assign azr[0]  = (ares[0] == 8'h00);
  assign azr[1]  = (ares[1] == 8'h00);

  alu_arbiter #(.SETTLE_CYCLES(S0)) dut0 (
    .clk(clk), .reset(rst[0]),
    .req0_valid(r0v[0]), .req0_ready(r0r[0]), .req0_data1(r0a[0]), .req0_data2(r0b[0]), .req0_select(r0s[0]),
    .req1_valid(r1v[0]), .req1_ready(r1r[0]), .req1_data1(r1a[0]), .req1_data2(r1b[0]), .req1_select(r1s[0]),
    .rsp_valid(rspv[0]), .rsp_ready(rspr[0]), .rsp_id(rid[0]), .rsp_result(rres[0]), .rsp_zero(rz[0]),
    .alu_data1(ad1[0]), .alu_data2(ad2[0]), .alu_select(asel[0]), .alu_result(ares[0]), .alu_zero(azr[0])
  );

  alu_arbiter #(.SETTLE_CYCLES(S1)) dut1 (
    .clk(clk), .reset(rst[1]),
    .req0_valid(r0v[1]), .req0_ready(r0r[1]), .req0_data1(r0a[1]), .req0_data2(r0b[1]), .req0_select(r0s[1]),
    .req1_valid(r1v[1]), .req1_ready(r1r[1]), .req1_data1(r1a[1]), .req1_data2(r1b[1]), .req1_select(r1s[1]),
    .rsp_valid(rspv[1]), .rsp_ready(rspr[1]), .rsp_id(rid[1]), .rsp_result(rres[1]), .rsp_zero(rz[1]),
    .alu_data1(ad1[1]), .alu_data2(ad2[1]), .alu_select(asel[1]), .alu_result(ares[1]), .alu_zero(azr[1])
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: one outstanding transaction per instance, due at accept edge + settle cycles.
  bit         m_pend [2];
  int         m_due [2];
  logic       m_last [2];
  logic       m_id [2];
  logic [7:0] m_res [2];
  logic       m_zero [2];
  logic [7:0] m_pres [2];
  logic [7:0] m_a1 [2];
  logic [7:0] m_a2 [2];
  logic [2:0] m_sel [2];
  int         dg0 [$];
  int         dg1 [$];

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  function automatic int settle_of(input int i);
    return (i == 0) ? S0 : S1;
  endfunction

  function automatic int dg_at(input int i, input int k);
    if (i == 0) return (dg0.size() > k) ? dg0[k] : -1;
    return (dg1.size() > k) ? dg1[k] : -1;
  endfunction

  task automatic tick();
    int   acc [2];
    logic cons [2];
    logic rs [2];
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      logic win;
      logic e0;
      logic e1;
      logic ev;
      win = (r0v[i] && r1v[i]) ? ~m_last[i] : r1v[i];
      e0 = !rst[i] && !m_pend[i] && r0v[i] && !win;
      e1 = !rst[i] && !m_pend[i] && r1v[i] && win;
      ev = m_pend[i] && (cyc >= m_due[i]);
      chk("req0_ready", i, r0r[i], e0);
      chk("req1_ready", i, r1r[i], e1);
      chk("rsp_valid", i, rspv[i], ev);
      chk("rsp_id", i, rid[i], m_id[i]);
      chk("rsp_result", i, rres[i], m_res[i]);
      chk("rsp_zero", i, rz[i], m_zero[i]);
      chk("alu_data1", i, ad1[i], m_a1[i]);
      chk("alu_data2", i, ad2[i], m_a2[i]);
      chk("alu_select", i, asel[i], m_sel[i]);
      acc[i] = e0 ? 0 : (e1 ? 1 : -1);
      cons[i] = ev && rspr[i];
      rs[i] = rst[i];
      if (r0r[i] && r0v[i]) begin
        if (i == 0) dg0.push_back(0); else dg1.push_back(0);
      end
      if (r1r[i] && r1v[i]) begin
        if (i == 0) dg0.push_back(1); else dg1.push_back(1);
      end
    end
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rs[i]) begin
        m_pend[i] = 0; m_last[i] = 1'b1; m_id[i] = 1'b0; m_res[i] = 8'h00; m_zero[i] = 1'b0;
        m_a1[i] = 8'h00; m_a2[i] = 8'h00; m_sel[i] = 3'd0;
      end else begin
        if (cons[i]) m_pend[i] = 0;
        if (acc[i] >= 0) begin
          m_pend[i] = 1;
          m_due[i]  = cyc + settle_of(i);
          m_id[i]   = acc[i][0];
          m_last[i] = acc[i][0];
          m_a1[i]   = (acc[i] == 0) ? r0a[i] : r1a[i];
          m_a2[i]   = (acc[i] == 0) ? r0b[i] : r1b[i];
          m_sel[i]  = (acc[i] == 0) ? r0s[i] : r1s[i];
          m_pres[i] = alu_fn(m_a1[i], m_a2[i], m_sel[i]);
        end else if (m_pend[i] && cyc == m_due[i]) begin
          m_res[i]  = m_pres[i];
          m_zero[i] = (m_pres[i] == 8'h00);
        end
      end
    end
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    for (int i = 0; i < 2; i++) begin
      if (r == 0) begin
        r0v[i] = v; r0a[i] = a; r0b[i] = b; r0s[i] = s;
      end else begin
        r1v[i] = v; r1a[i] = a; r1b[i] = b; r1s[i] = s;
      end
    end
  endtask

  task automatic set_all(input logic rst_v, input logic rdy_v);
    for (int i = 0; i < 2; i++) begin
      rst[i] = rst_v;
      rspr[i] = rdy_v;
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_due[i] = 0; m_last[i] = 1'b1; m_id[i] = 1'b0; m_res[i] = 8'h00;
      m_zero[i] = 1'b0; m_pres[i] = 8'h00; m_a1[i] = 8'h00; m_a2[i] = 8'h00; m_sel[i] = 3'd0;
    end
    set_req(0, 1'b0, 8'h00, 8'h00, 3'd0);
    set_req(1, 1'b0, 8'h00, 8'h00, 3'd0);
    set_all(1'b1, 1'b1);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("ready0_in_reset", i, r0r[i], 1'b0);
    end
    tick();
    tick();
    set_all(1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      chk("reset_rsp_valid", i, rspv[i], 1'b0);
      chk("reset_alu_data1", i, ad1[i], 8'h00);
    end

    // 5 + 3 on requester 0, single settle cycle on instance 0
    set_req(0, 1'b1, 8'd5, 8'd3, 3'b001);
    tick();
    set_req(0, 1'b0, 8'd5, 8'd3, 3'b001);
    tick();
    chk("req035_valid", 0, rspv[0], 1'b1);
    chk("req035_id", 0, rid[0], 1'b0);
    chk("req035_result", 0, rres[0], 8'd8);
    chk("req035_zero", 0, rz[0], 1'b0);
    repeat (6) tick();

    // Continuous contention alternates grants from a fresh reset
    set_all(1'b1, 1'b1);
    tick();
    set_all(1'b0, 1'b1);
    dg0.delete();
    dg1.delete();
    set_req(0, 1'b1, 8'h0F, 8'hF0, 3'b010);
    set_req(1, 1'b1, 8'h0F, 8'hF0, 3'b011);
    repeat (24) tick();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) begin
        chk("req036_grant", i, dg_at(i, k), k % 2);
      end
    end
    set_req(0, 1'b0, 8'h00, 8'h00, 3'd0);
    set_req(1, 1'b0, 8'h00, 8'h00, 3'd0);
    repeat (8) tick();

    // Backpressure: response held while both requesters wait
    set_all(1'b0, 1'b0);
    set_req(0, 1'b1, 8'd10, 8'd20, 3'b001);
    tick();
    set_req(1, 1'b1, 8'd7, 8'd2, 3'b000);
    repeat (8) tick();
    chk("req037_held", 1, rspv[1], 1'b1);
    chk("req037_held", 0, rspv[0], 1'b1);
    set_all(1'b0, 1'b1);
    tick();
    set_req(0, 1'b0, 8'h00, 8'h00, 3'd0);
    set_req(1, 1'b0, 8'h00, 8'h00, 3'd0);
    repeat (10) tick();

    // 127 + 1 on the three-cycle instance
    set_req(0, 1'b1, 8'd127, 8'd1, 3'b001);
    tick();
    set_req(0, 1'b0, 8'd0, 8'd0, 3'b000);
    n = 0;
    while (!rspv[1] && n < 10) begin
      tick();
      n++;
    end
    chk("req038_latency", 1, n, 3);
    chk("req038_result", 1, rres[1], 8'h80);
    chk("req038_zero", 1, rz[1], 1'b0);
    repeat (6) tick();

    // Opcode 101 passed straight through; model ALU returns zero for it
    set_req(1, 1'b1, 8'h55, 8'h00, 3'b101);
    tick();
    set_req(1, 1'b0, 8'h00, 8'h00, 3'd0);
    n = 0;
    while (!rspv[0] && n < 10) begin
      tick();
      n++;
    end
    chk("req040_result", 0, rres[0], 8'h00);
    chk("req040_zero", 0, rz[0], 1'b1);
    chk("req040_select", 0, asel[0], 3'b101);
    repeat (6) tick();

    // Reset during settle abandons the operation
    set_req(1, 1'b1, 8'd9, 8'd9, 3'b001);
    tick();
    set_all(1'b1, 1'b1);
    set_req(0, 1'b1, 8'd1, 8'd1, 3'b001);
    tick();
    set_all(1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      chk("req039_valid", i, rspv[i], 1'b0);
      chk("req039_data1", i, ad1[i], 8'h00);
      chk("req039_result", i, rres[i], 8'h00);
    end
    dg0.delete();
    dg1.delete();
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("req039_first_grant", i, dg_at(i, 0), 0);
    end
    set_req(0, 1'b0, 8'h00, 8'h00, 3'd0);
    set_req(1, 1'b0, 8'h00, 8'h00, 3'd0);
    repeat (10) tick();

    // Randomized traffic with occasional resets and backpressure
    for (int t = 0; t < 500; t++) begin
      for (int i = 0; i < 2; i++) begin
        rst[i]  = ($urandom_range(0, 63) == 0);
        rspr[i] = ($urandom_range(0, 3) != 0);
        r0v[i]  = ($urandom_range(0, 2) != 0);
        r1v[i]  = ($urandom_range(0, 2) != 0);
        r0a[i]  = 8'($urandom);
        r0b[i]  = 8'($urandom);
        r0s[i]  = 3'($urandom);
        r1a[i]  = 8'($urandom);
        r1b[i]  = 8'($urandom);
        r1s[i]  = 3'($urandom);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
